// File: rtl/scalar_pkg.sv
// Shared types for the scalar register-file write-back path: widths,
// source-select encoding and the buffered write entry.
package scalar_pkg;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/scalar_wb_arbiter_if.sv
// Producer, write-port and hazard-query signals of the write-back arbiter.
// slave = arbiter side, master = surrounding pipeline side.
interface scalar_wb_arbiter_if import scalar_pkg::*; #(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  logic          wr_hold;
  logic          wr_en;
  logic [AW-1:0] wr_dst;
  logic [DW-1:0] wr_data;

  logic [AW-1:0] q_addr_1;
  logic [AW-1:0] q_addr_2;
  logic          q_pend_1;
  logic          q_pend_2;
  logic [DW-1:0] q_data_1;
  logic [DW-1:0] q_data_2;

  logic [OW-1:0] occupancy;

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    output alu_ready,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready,
    input  wr_hold,
    output wr_en, wr_dst, wr_data,
    input  q_addr_1, q_addr_2,
    output q_pend_1, q_pend_2, q_data_1, q_data_2,
    output occupancy
  );

  modport master (
    output alu_valid, alu_dst, alu_data,
    input  alu_ready,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready,
    output wr_hold,
    input  wr_en, wr_dst, wr_data,
    output q_addr_1, q_addr_2,
    input  q_pend_1, q_pend_2, q_data_1, q_data_2,
    input  occupancy
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order write-back FIFO; exposes raw storage, read pointer and a per-slot
// valid vector so the parent can match pending destinations.
module wb_fifo import scalar_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  wb_entry_t                   i_push_entry,
  input  logic                        i_pop,
  output wb_entry_t [DEPTH-1:0]       o_mem,
  output logic [$clog2(DEPTH)-1:0]    o_rd_ptr,
  output logic [DEPTH-1:0]            o_valid_vec,
  output logic [$clog2(DEPTH):0]      o_occupancy,
  output logic                        o_empty,
  output logic                        o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;

  // Pointers wrap naturally at DEPTH; occupancy disambiguates full/empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // A slot is live when its distance from the read pointer is below occupancy
  always_comb begin
    logic [PW-1:0] w_age;
    w_age       = '0;
    o_valid_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_age                  = PW'(i) - r_rd_ptr;
      o_valid_vec[PW'(i)]    = ({1'b0, w_age} < r_occ);
    end
  end

  assign o_mem       = r_mem;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_occupancy = r_occ;
  assign o_empty     = (r_occ == '0);
  assign o_full      = (r_occ == OW'(DEPTH));

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Write-back arbiter: round-robin merge of ALU and load results into an
// in-order FIFO draining to the register-file write port, plus hazard query.
// Optional WB_BYPASS_EN: forward youngest matching buffered data on q_data_*.
module scalar_wb_arbiter import scalar_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  scalar_wb_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  src_e                  r_rr;
  src_e                  w_rr_next;
  logic                  w_grant_alu;
  logic                  w_grant_mem;
  logic                  w_alu_ready;
  logic                  w_mem_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_space;
  logic                  w_full;
  logic                  w_empty;
  wb_entry_t             w_push_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic [DEPTH-1:0]      w_valid_vec;
  logic [PW-1:0]         w_rd_ptr;
  logic [OW-1:0]         w_occ;
  logic                  w_pend_1;
  logic                  w_pend_2;
  logic [DW-1:0]         w_q_data_1;
  logic [DW-1:0]         w_q_data_2;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_mem        (w_mem),
    .o_rd_ptr     (w_rd_ptr),
    .o_valid_vec  (w_valid_vec),
    .o_occupancy  (w_occ),
    .o_empty      (w_empty),
    .o_full       (w_full)
  );

  assign w_head  = w_mem[w_rd_ptr];
  assign w_pop   = !rst && !w_empty && !bus.wr_hold;
  assign w_space = !w_full || w_pop;

  always_ff @(posedge clk) begin
    if (rst) r_rr <= SRC_MEM;
    else     r_rr <= w_rr_next;
  end

  // Grant uses only the competing source's valid, so ready never loops on own valid
  always_comb begin
    w_rr_next    = r_rr;
    w_grant_alu  = !bus.mem_valid || (r_rr == SRC_ALU);
    w_grant_mem  = !bus.alu_valid || (r_rr == SRC_MEM);
    w_alu_ready  = !rst && w_space && w_grant_alu;
    w_mem_ready  = !rst && w_space && w_grant_mem;
    w_push       = (bus.alu_valid && w_alu_ready) || (bus.mem_valid && w_mem_ready);
    w_push_entry.dst  = bus.alu_dst;
    w_push_entry.data = bus.alu_data;
    if (bus.mem_valid && w_mem_ready) begin
      w_push_entry.dst  = bus.mem_dst;
      w_push_entry.data = bus.mem_data;
    end
    if (bus.alu_valid && bus.mem_valid && w_push)
      w_rr_next = (r_rr == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

  always_comb begin
    w_pend_1 = 1'b0;
    w_pend_2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid_vec[PW'(i)] && (w_mem[PW'(i)].dst == bus.q_addr_1)) w_pend_1 = 1'b1;
      if (w_valid_vec[PW'(i)] && (w_mem[PW'(i)].dst == bus.q_addr_2)) w_pend_2 = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match is the youngest write
  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx      = '0;
    w_q_data_1 = '0;
    w_q_data_2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PW'(k);
      if (w_valid_vec[w_idx] && (w_mem[w_idx].dst == bus.q_addr_1)) w_q_data_1 = w_mem[w_idx].data;
      if (w_valid_vec[w_idx] && (w_mem[w_idx].dst == bus.q_addr_2)) w_q_data_2 = w_mem[w_idx].data;
    end
  end
`else
  assign w_q_data_1 = '0;
  assign w_q_data_2 = '0;
`endif

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.wr_en     = w_pop;
  assign bus.wr_dst    = w_head.dst;
  assign bus.wr_data   = w_head.data;
  assign bus.q_pend_1  = w_pend_1;
  assign bus.q_pend_2  = w_pend_2;
  assign bus.q_data_1  = w_q_data_1;
  assign bus.q_data_2  = w_q_data_2;
  assign bus.occupancy = w_occ;

endmodule
